diffeq_loop: RTL



---
 rtl/diffeq_pkg.sv | 24 ++
 rtl/diffeq.sv | 70 +++++++
 rtl/diffeq_loop.sv | 139 +++++++++++++
 3 files changed

// File: rtl/diffeq_pkg.sv
// Shared types and constants for the diffeq iteration loop
// and its single-step datapath.
package diffeq_pkg;
    localparam int DATA_W = 32;

    typedef logic signed [DATA_W-1:0] data_t;

    localparam data_t K3 = 32'sd3;

    typedef enum logic [1:0] {
        S_IDLE,
        S_CHECK,
        S_STEP,
        S_DONE
    } loop_state_e;

    typedef enum logic [2:0] {
        D_IDLE,
        D_MUL1,
        D_MUL2,
        D_UPD,
        D_DONE
    } step_state_e;
endpackage

// File: rtl/diffeq.sv
// Single-step diffeq datapath: returns y + u'*dx where
// u' = u - 3*x*u*dx - 3*y*dx. Inputs are read live in later states.
module diffeq
    import diffeq_pkg::*;
(
    input  logic  ap_clk,
    input  logic  ap_rst,
    input  logic  ap_start,
    output logic  ap_done,
    output logic  ap_idle,
    output logic  ap_ready,
    input  data_t x,
    input  data_t dx,
    input  data_t u,
    input  data_t y,
    output data_t ap_return
);

    step_state_e r_state;
    step_state_e w_next;
    data_t       r_xu;
    data_t       r_xudx;
    data_t       r_ydx;
    data_t       r_un;

    // State register
    always_ff @(posedge ap_clk) begin
        if (ap_rst) r_state <= D_IDLE;
        else        r_state <= w_next;
    end

    // Next-state: fixed three busy cycles then a done cycle
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            D_IDLE: if (ap_start) w_next = D_MUL1;
            D_MUL1: w_next = D_MUL2;
            D_MUL2: w_next = D_UPD;
            D_UPD:  w_next = D_DONE;
            D_DONE: w_next = D_IDLE;
            default: w_next = D_IDLE;
        endcase
    end

    // Multi-cycle product pipeline for the u update
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_xu   <= '0;
            r_xudx <= '0;
            r_ydx  <= '0;
            r_un   <= '0;
        end else begin
            unique case (r_state)
                D_MUL1: r_xu <= x * u;
                D_MUL2: begin
                    r_xudx <= r_xu * dx;
                    r_ydx  <= y * dx;
                end
                D_UPD:  r_un <= u - K3 * r_xudx - K3 * r_ydx;
                default: ;
            endcase
        end
    end

    assign ap_idle   = (r_state == D_IDLE);
    assign ap_done   = (r_state == D_DONE);
    assign ap_ready  = ap_done;
    assign ap_return = y + r_un * dx;

endmodule

// File: rtl/diffeq_loop.sv
// Iteration controller: drives diffeq until x >= a or the
// iteration cap is reached, then reports via ap_* handshake.
module diffeq_loop
    import diffeq_pkg::*;
#(
    parameter int MAX_ITER = 1024,
    parameter int ITER_W   = 16
) (
    input  logic              ap_clk,
    input  logic              ap_rst_n,
    input  logic              ap_start,
    output logic              ap_done,
    output logic              ap_idle,
    output logic              ap_ready,
    input  data_t             x0,
    input  data_t             dx,
    input  data_t             u0,
    input  data_t             y0,
    input  data_t             a,
    output data_t             x_out,
    output data_t             u_out,
    output data_t             y_out,
    output logic [ITER_W-1:0] iter_out,
    output logic              hit_max
);

    localparam logic [ITER_W-1:0] ITER_CAP = ITER_W'(MAX_ITER);

    loop_state_e       r_state;
    loop_state_e       w_next;
    data_t             r_x;
    data_t             r_dx;
    data_t             r_u;
    data_t             r_y;
    data_t             r_a;
    logic [ITER_W-1:0] r_iter;
    logic              r_hit;

    logic  w_step_rst;
    logic  w_step_start;
    logic  w_step_done;
    logic  w_step_idle;
    logic  w_step_ready;
    logic  w_step_fin;
    data_t w_step_ret;
    data_t w_u_next;
    logic  w_reached;
    logic  w_capped;

    assign w_step_rst = ~ap_rst_n;
    // Step block is idle only in the first STEP cycle of an iteration
    assign w_step_start = (r_state == S_STEP) & w_step_idle;
    assign w_step_fin   = w_step_done & w_step_ready;
    assign w_reached    = (r_x >= r_a);
    assign w_capped     = (r_iter == ITER_CAP);
    assign w_u_next     = r_u - K3 * r_x * r_u * r_dx - K3 * r_y * r_dx;

    diffeq u_step (
        .ap_clk    (ap_clk),
        .ap_rst    (w_step_rst),
        .ap_start  (w_step_start),
        .ap_done   (w_step_done),
        .ap_idle   (w_step_idle),
        .ap_ready  (w_step_ready),
        .x         (r_x),
        .dx        (r_dx),
        .u         (r_u),
        .y         (r_y),
        .ap_return (w_step_ret)
    );

    // State register
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) r_state <= S_IDLE;
        else           r_state <= w_next;
    end

    // Next-state logic
    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE:  if (ap_start) w_next = S_CHECK;
            S_CHECK: begin
                if (w_reached || w_capped) w_next = S_DONE;
                else                       w_next = S_STEP;
            end
            S_STEP:  if (w_step_fin) w_next = S_CHECK;
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Loop state: load on accept, update on step completion
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            r_x    <= '0;
            r_dx   <= '0;
            r_u    <= '0;
            r_y    <= '0;
            r_a    <= '0;
            r_iter <= '0;
            r_hit  <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (ap_start) begin
                        r_x    <= x0;
                        r_dx   <= dx;
                        r_u    <= u0;
                        r_y    <= y0;
                        r_a    <= a;
                        r_iter <= '0;
                        r_hit  <= 1'b0;
                    end
                end
                S_CHECK: r_hit <= ~w_reached & w_capped;
                S_STEP: begin
                    if (w_step_fin) begin
                        r_x    <= r_x + r_dx;
                        r_u    <= w_u_next;
                        r_y    <= w_step_ret;
                        r_iter <= r_iter + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign ap_done  = (r_state == S_DONE);
    assign ap_ready = ap_done;
    assign ap_idle  = (r_state == S_IDLE) & ~ap_start;
    assign x_out    = r_x;
    assign u_out    = r_u;
    assign y_out    = r_y;
    assign iter_out = r_iter;
    assign hit_max  = r_hit;

endmodule
